// File: rtl/dkong3_audio_pkg.sv
// dkong3_audio_pkg: shared constants for the audio output path (optional HPF via DKONG3_AUDIO_DCBLOCK_EN)
package dkong3_audio_pkg;
  localparam int DECIM_DIV = 500;
  localparam int LPF_SHIFT = 8;
  localparam int HPF_SHIFT = 10;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 24;
  localparam int CNT_W     = $clog2(DECIM_DIV);
endpackage

// File: rtl/dkong3_audio_sat.sv
// dkong3_audio_sat: gain shift of a 24-bit sample followed by a clamp to signed 16 bits
module dkong3_audio_sat
  import dkong3_audio_pkg::*;
(
  input  logic signed [ACC_W-1:0] din,
  input  logic        [1:0]       gain,
  output logic signed [15:0]      dout
);
  logic signed [ACC_W+2:0] sh;
  always_comb begin
    sh = $signed({{3{din[ACC_W-1]}}, din}) <<< gain;
    dout = sh > 32767 ? 16'sh7fff : sh < -32768 ? 16'sh8000 : sh[15:0];
  end
endmodule

// File: rtl/dkong3_audio_out.sv
// dkong3_audio_out: LPF, /500 decimation, optional DC-block (DKONG3_AUDIO_DCBLOCK_EN), gain and clamp
module dkong3_audio_out
  import dkong3_audio_pkg::*;
(
  input  logic               I_CLK_24M,
  input  logic               I_RESET,
  input  logic signed [15:0] I_SAMPLE,
  input  logic        [1:0]  I_GAIN,
  output logic signed [15:0] O_AUDIO,
  output logic               O_STB
);
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   diff;
  logic signed [15:0]      d;
  logic signed [15:0]      dout;
  logic signed [ACC_W-1:0] stage;
  logic                    decim;
  assign decim = cnt == CNT_W'(DECIM_DIV - 1);
  // One bit of headroom so x - acc cannot wrap before the shift
  assign diff  = $signed({I_SAMPLE[15], I_SAMPLE, {FRAC_BITS{1'b0}}}) - $signed({acc[ACC_W-1], acc});
  assign d     = acc[ACC_W-1:FRAC_BITS];
`ifdef DKONG3_AUDIO_DCBLOCK_EN
  logic signed [15:0]      d_prev;
  logic signed [ACC_W-1:0] y_prev;
  logic signed [ACC_W-1:0] y_leak;
  logic signed [ACC_W-1:0] y;
  // Leak is computed on its own so the shift stays arithmetic
  assign y_leak = y_prev >>> HPF_SHIFT;
  assign y      = {d, {FRAC_BITS{1'b0}}} - {d_prev, {FRAC_BITS{1'b0}}} + y_prev - y_leak;
  assign stage  = {{FRAC_BITS{y[ACC_W-1]}}, y[ACC_W-1:FRAC_BITS]};
  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      d_prev <= '0;
      y_prev <= '0;
    end else if (decim) begin
      d_prev <= d;
      y_prev <= y;
    end
  end
`else
  assign stage = {{FRAC_BITS{d[15]}}, d};
`endif
  dkong3_audio_sat u_sat (
    .din  (stage),
    .gain (I_GAIN),
    .dout (dout)
  );
  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      cnt     <= '0;
      acc     <= '0;
      O_AUDIO <= '0;
      O_STB   <= 1'b0;
    end else begin
      cnt   <= decim ? '0 : cnt + CNT_W'(1);
      acc   <= acc + ACC_W'(diff >>> LPF_SHIFT);
      O_STB <= decim;
      if (decim) O_AUDIO <= dout;
    end
  end
endmodule

// File: doc/dkong3_audio_out.md
DKONG3_AUDIO_OUT -- requirements
Module: dkong3_audio_out

Interface
REQ-001 SHALL have port I_CLK_24M, input, 1 bit: the single clock, 24 MHz system clock; all logic is on its rising edge.
REQ-002 SHALL have port I_RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port I_SAMPLE, input, 16 bits signed: raw game audio (O_SOUND_DAT of the game top), sampled every clock.
REQ-004 SHALL have port I_GAIN, input, 2 bits: output gain as a left shift of 0..3 (x1, x2, x4, x8).
REQ-005 SHALL have port O_AUDIO, output, 16 bits signed: filtered, decimated, gain-scaled sample for the framework audio path.
REQ-006 SHALL have port O_STB, output, 1 bit: one-clock pulse marking each new O_AUDIO value (48 kHz).

Function
REQ-007 SHALL run a decimation counter 0..499 that increments every clock and wraps from 499 to 0, giving exactly 48 000 strobes/s.
REQ-008 SHALL run a one-pole anti-alias low-pass every clock: acc += (x - acc) >>> 8 (arithmetic shift).
REQ-009 SHALL keep acc as 24-bit signed with 8 fractional bits; x is I_SAMPLE sign-extended and shifted left by 8.
REQ-010 SHALL take the LPF integer part (acc[23:8]) as the decimated sample d on the clock where the counter equals 499.
REQ-011 SHALL, when DC blocking is built (REQ-019), compute at each decimation: y = d - d_prev + y_prev - (y_prev >>> 10).
REQ-012 SHALL keep y as 24-bit signed with 8 fractional bits, and update d_prev and y_prev only at decimation.
REQ-013 SHALL left-shift the stage result (integer part) by I_GAIN, using the I_GAIN value sampled at the decimation clock.
REQ-014 SHALL saturate the shifted result to [-32768, +32767].
REQ-015 SHALL register O_AUDIO and assert O_STB on the clock after the counter equals 499.
REQ-016 SHALL hold O_AUDIO stable between strobes and keep O_STB low except on strobe clocks.
REQ-017 SHALL give an I_SAMPLE-to-LPF latency of 1 clock and a decimation-to-O_AUDIO latency of 1 clock; there is no back-pressure.
REQ-018 SHALL make I_GAIN changes take effect at the next strobe only, never mid-sample.

Configuration
REQ-019 SHALL compile the DC-blocking high-pass (REQ-011/012) in only when macro DKONG3_AUDIO_DCBLOCK_EN is defined.
REQ-020 SHALL, without DKONG3_AUDIO_DCBLOCK_EN, remove the HPF registers entirely and feed d directly to the gain stage.

Reset
REQ-021 SHALL, while I_RESET is high, clear counter, acc, d_prev, y_prev and O_AUDIO to 0, and hold O_STB at 0.
REQ-022 SHALL make the first O_STB after reset release occur exactly 500 clocks after the first clock with I_RESET low.
REQ-023 SHALL let reset asserted mid-operation (including on a strobe clock) override everything: O_STB=0 and O_AUDIO=0 on the next clock.

Structure
REQ-024 SHALL place constants in package dkong3_audio_pkg: DECIM_DIV=500, LPF_SHIFT=8, HPF_SHIFT=10, FRAC_BITS=8, ACC_W=24.
REQ-025 SHALL implement the gain/saturation stage as sub-module dkong3_audio_sat (combinational shift plus clamp, 24-bit in, 16-bit out).

Verification
REQ-026 SHALL cover reset: I_RESET high for 10 clocks, then low -> O_AUDIO=0 throughout and first O_STB at exactly release+500 clocks.
REQ-027 SHALL cover strobe timing: free-run 20 strobes -> every O_STB one clock wide and exactly 500 clocks apart.
REQ-028 SHALL cover a step with DCBLOCK off and I_GAIN=0: I_SAMPLE 0 -> 16384 -> O_AUDIO within ±1 of 16384 by the 9th strobe after the step.
REQ-029 SHALL cover saturation: I_SAMPLE=20000 with I_GAIN=1 -> 32767; I_SAMPLE=-20000 -> -32768; I_SAMPLE=1000 with I_GAIN=3 -> 8000 (±1).
REQ-030 SHALL cover DCBLOCK on: constant 16384 -> first post-step outputs peak between 12000 and 16384, then |O_AUDIO| < 64 after 8192 strobes.
REQ-031 SHALL cover reset mid-run: I_RESET pulsed 1 clock coincident with counter=499 -> no O_STB, O_AUDIO=0, next O_STB 500 clocks later.
